rtos_wb_rr_arbiter: RTL and testbench
=====================================

// Module: rtos_wb_rr_arbiter
// PURPOSE
//  Round-robin WISHBONE arbiter: shares one peripheral slave port (e.g. the RTOS semaphore/
//  core register bus) between NUM classic-cycle WISHBONE masters (CPUs, DMA, test master).
//  A per-master lock input keeps the grant across back-to-back cycles for atomic
//  read-modify-write of semaphore counters. Sits between the masters and the slave's wb_peri_* port.
// PARAMETERS
//  NUM           4                   number of masters (>=2)
//  WB_ADR_WIDTH  37                  word address width (40-bit byte space, 64-bit data)
//  WB_DAT_WIDTH  64                  data width
//  WB_SEL_WIDTH  WB_DAT_WIDTH/8      byte-select width
//  ID_WIDTH      $clog2(NUM)         grant index width
// PORTS
//  clk          in   1                  single clock, all logic on posedge
//  reset_n      in   1                  synchronous reset, active-low (0 = reset)
//  s_wb_adr_i   in   NUM*WB_ADR_WIDTH   master addresses, master k at slice k
//  s_wb_dat_i   in   NUM*WB_DAT_WIDTH   master write data
//  s_wb_dat_o   out  WB_DAT_WIDTH       read data, broadcast to all masters
//  s_wb_we_i    in   NUM                write enable per master
//  s_wb_sel_i   in   NUM*WB_SEL_WIDTH   byte selects
//  s_wb_stb_i   in   NUM                cycle request per master
//  s_wb_lock_i  in   NUM                hold grant after ack (atomic sequence)
//  s_wb_ack_o   out  NUM                ack, only the granted master's bit can be 1
//  m_wb_adr_o   out  WB_ADR_WIDTH       to slave: muxed address
//  m_wb_dat_o   out  WB_DAT_WIDTH       to slave: muxed write data
//  m_wb_dat_i   in   WB_DAT_WIDTH       from slave: read data
//  m_wb_we_o    out  1                  muxed we
//  m_wb_sel_o   out  WB_SEL_WIDTH       muxed sel
//  m_wb_stb_o   out  1                  stb of granted master, gated by BUSY state
//  m_wb_ack_i   in   1                  slave ack (may be multi-cycle latency)
//  grant_o      out  ID_WIDTH           current/last grant index (debug)
//  busy_o       out  1                  1 while in BUSY
// BEHAVIOUR
//  - State regs: state{IDLE,BUSY}, grant (ID_WIDTH), last (ID_WIDTH). Reset: IDLE, grant=0,
//    last=NUM-1 (so master 0 wins first). Outputs in reset: m_wb_stb_o=0, s_wb_ack_o=0, busy_o=0.
//  - IDLE: if |s_wb_stb_i, grant<=first requester scanning last+1, last+2 .. wrapping mod NUM
//    (last itself lowest priority); state<=BUSY. No stb -> stay IDLE.
//  - Latency: stb asserted in IDLE cycle t -> m_wb_stb_o=1 at t+1. Masters holding stb
//    wait; no request is dropped.
//  - BUSY: m_wb_{adr,dat,we,sel}_o = slice[grant] (combinational mux from registered grant);
//    m_wb_stb_o = s_wb_stb_i[grant]; s_wb_ack_o = m_wb_ack_i << grant (others 0).
//  - BUSY exit: m_wb_ack_i & ~s_wb_lock_i[grant] -> IDLE, last<=grant. With lock=1 the
//    grant is kept; next cycle of same master passes straight through (no re-arbitration).
//  - Abort: granted master drops stb and lock both 0 without ack -> IDLE, last<=grant.
//    lock=1 & stb=0 -> stay BUSY (master owns bus between atomic halves).
//  - One idle cycle between non-locked transactions (IDLE re-arbitration cycle); worst-case
//    wait for any requester = NUM-1 transactions (fairness guarantee).
//  - m_wb_ack_i while in IDLE is ignored (no s_wb_ack_o). s_wb_dat_o = m_wb_dat_i always.
//  - reset_n=0 mid-transaction: next edge returns to IDLE/reset values; slave sees stb drop.
//  - NUM not power of two: wrap computed explicitly mod NUM; grant never >= NUM.
// STRUCTURE
//  - Package rtos_wb_pkg: typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t; WB width localparams.
//  - Sub-module rtos_rr_pick #(NUM): combinational; in req[NUM], last -> out valid, idx
//    (rotating priority encoder). Arbiter = FSM + rtos_rr_pick + output muxes.
// TESTING
//  - Single master 1 read adr 0, slave ack 2 cycles later -> m_wb_stb_o rises 1 clk after stb,
//    s_wb_ack_o=4'b0010, dat 0x0123456789abcdef returned, busy_o falls after ack.
//  - All 4 stb held continuously, 1-cycle slave -> grant order 0,1,2,3,0,1; each ack only on own bit.
//  - Master 2 lock=1 for read then write (sel 8'h0f) while master 0 requests -> master 0 not
//    granted until master 2 ack with lock=0; both m_wb cycles carry master 2 adr/dat.
//  - Granted master 3 drops stb before ack, lock=0 -> IDLE next clk, next grant goes to 0.
//  - reset_n=0 asserted while BUSY with stb high -> next clk m_wb_stb_o=0, grant_o=0;
//    after release, first grant goes to lowest pending index.
//  - Spurious m_wb_ack_i in IDLE -> s_wb_ack_o stays 4'b0000, state unchanged.

Source files
------------

// File: rtl/rtos_wb_rr_arbiter_pkg.sv
// rtos_wb_pkg: arbiter state type and default WISHBONE widths (40-bit byte space, 64-bit data).
package rtos_wb_pkg;
   typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;
   localparam int WB_ADR_W = 37;
   localparam int WB_DAT_W = 64;
   localparam int WB_SEL_W = WB_DAT_W / 8;
endpackage

// File: rtl/rtos_wb_rr_arbiter_pick.sv
// rtos_rr_pick: rotating priority encoder, first requester after last (last itself lowest).
module rtos_rr_pick #(
   parameter int NUM      = 4,
   parameter int ID_WIDTH = $clog2(NUM)
) (
   input  logic [NUM-1:0]      req_i,
   input  logic [ID_WIDTH-1:0] last_i,
   output logic                valid_o,
   output logic [ID_WIDTH-1:0] idx_o
);
   int k;
   always_comb begin
      valid_o = |req_i;
      idx_o   = '0;
      k       = 0;
      // scan farthest first so the nearest requester after last wins; wrap without % for any NUM
      for (int i = NUM; i >= 1; i--) begin
         k = int'(last_i) + i;
         k = (k >= NUM) ? k - NUM : k;
         if (req_i[k]) idx_o = ID_WIDTH'(k);
      end
   end
endmodule

// File: rtl/rtos_wb_rr_arbiter.sv
// rtos_wb_rr_arbiter: round-robin arbiter sharing one classic WISHBONE slave among NUM masters,
// with per-master lock to hold the bus across atomic read-modify-write sequences.
module rtos_wb_rr_arbiter
   import rtos_wb_pkg::*;
#(
   parameter int NUM          = 4,
   parameter int WB_ADR_WIDTH = WB_ADR_W,
   parameter int WB_DAT_WIDTH = WB_DAT_W,
   parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
   parameter int ID_WIDTH     = $clog2(NUM)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM*WB_ADR_WIDTH-1:0] s_wb_adr_i,
   input  logic [NUM*WB_DAT_WIDTH-1:0] s_wb_dat_i,
   output logic [WB_DAT_WIDTH-1:0]     s_wb_dat_o,
   input  logic [NUM-1:0]              s_wb_we_i,
   input  logic [NUM*WB_SEL_WIDTH-1:0] s_wb_sel_i,
   input  logic [NUM-1:0]              s_wb_stb_i,
   input  logic [NUM-1:0]              s_wb_lock_i,
   output logic [NUM-1:0]              s_wb_ack_o,
   output logic [WB_ADR_WIDTH-1:0]     m_wb_adr_o,
   output logic [WB_DAT_WIDTH-1:0]     m_wb_dat_o,
   input  logic [WB_DAT_WIDTH-1:0]     m_wb_dat_i,
   output logic                        m_wb_we_o,
   output logic [WB_SEL_WIDTH-1:0]     m_wb_sel_o,
   output logic                        m_wb_stb_o,
   input  logic                        m_wb_ack_i,
   output logic [ID_WIDTH-1:0]         grant_o,
   output logic                        busy_o
);
   arb_state_t          state_q;
   logic [ID_WIDTH-1:0] grant_q, last_q, pick_idx;
   logic                pick_valid, busy;

   rtos_rr_pick #(.NUM(NUM), .ID_WIDTH(ID_WIDTH)) u_pick (
      .req_i   (s_wb_stb_i),
      .last_i  (last_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= ID_WIDTH'(NUM - 1);
      end else if (state_q == ST_IDLE) begin
         if (pick_valid) begin
            state_q <= ST_BUSY;
            grant_q <= pick_idx;
         end
      end else if (!s_wb_lock_i[grant_q] && (m_wb_ack_i || !s_wb_stb_i[grant_q])) begin
         // release on ack or abort; a locked owner keeps the bus even with stb low
         state_q <= ST_IDLE;
         last_q  <= grant_q;
      end
   end

   assign busy       = state_q == ST_BUSY;
   assign busy_o     = busy;
   assign grant_o    = grant_q;
   assign m_wb_adr_o = s_wb_adr_i[int'(grant_q)*WB_ADR_WIDTH +: WB_ADR_WIDTH];
   assign m_wb_dat_o = s_wb_dat_i[int'(grant_q)*WB_DAT_WIDTH +: WB_DAT_WIDTH];
   assign m_wb_sel_o = s_wb_sel_i[int'(grant_q)*WB_SEL_WIDTH +: WB_SEL_WIDTH];
   assign m_wb_we_o  = s_wb_we_i[grant_q];
   assign m_wb_stb_o = busy && s_wb_stb_i[grant_q];
   assign s_wb_ack_o = busy ? {{(NUM-1){1'b0}}, m_wb_ack_i} << grant_q : '0;
   assign s_wb_dat_o = m_wb_dat_i;
endmodule

// File: tb/tb_rtos_wb_rr_arbiter.sv
// tb_rtos_wb_rr_arbiter: scoreboard bench; expected slave cycles queued at request time, checked at slave ack.
module tb_rtos_wb_rr_arbiter;
   localparam int NUM = 4;
   localparam int AW  = 37;
   localparam int DW  = 64;
   localparam int SW  = 8;

   typedef struct {
      int            m;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic          we;
      logic [SW-1:0] sel;
   } exp_t;

   logic              clk = 0;
   logic              reset_n = 0;
   logic [NUM*AW-1:0] s_wb_adr_i = '0;
   logic [NUM*DW-1:0] s_wb_dat_i = '0;
   logic [DW-1:0]     s_wb_dat_o;
   logic [NUM-1:0]    s_wb_we_i = '0;
   logic [NUM*SW-1:0] s_wb_sel_i = '0;
   logic [NUM-1:0]    s_wb_stb_i = '0;
   logic [NUM-1:0]    s_wb_lock_i = '0;
   logic [NUM-1:0]    s_wb_ack_o;
   logic [AW-1:0]     m_wb_adr_o;
   logic [DW-1:0]     m_wb_dat_o;
   logic [DW-1:0]     m_wb_dat_i = '0;
   logic              m_wb_we_o;
   logic [SW-1:0]     m_wb_sel_o;
   logic              m_wb_stb_o;
   logic              m_wb_ack_i = 0;
   logic [1:0]        grant_o;
   logic              busy_o;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   rtos_wb_rr_arbiter #(.NUM(NUM), .WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
      .s_wb_we_i(s_wb_we_i), .s_wb_sel_i(s_wb_sel_i), .s_wb_stb_i(s_wb_stb_i),
      .s_wb_lock_i(s_wb_lock_i), .s_wb_ack_o(s_wb_ack_o),
      .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i),
      .m_wb_we_o(m_wb_we_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_stb_o(m_wb_stb_o),
      .m_wb_ack_i(m_wb_ack_i), .grant_o(grant_o), .busy_o(busy_o)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic we, input logic [SW-1:0] sel, input logic lock);
      s_wb_adr_i[k*AW +: AW] = adr;
      s_wb_dat_i[k*DW +: DW] = dat;
      s_wb_sel_i[k*SW +: SW] = sel;
      s_wb_we_i[k]   = we;
      s_wb_lock_i[k] = lock;
      s_wb_stb_i[k]  = 1'b1;
   endtask

   task automatic push(input int k, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic we, input logic [SW-1:0] sel);
      exp_t e;
      e.m = k; e.adr = adr; e.dat = dat; e.we = we; e.sel = sel;
      sb.push_back(e);
   endtask

   // slave: wait for stb, ack after lat cycles, compare the cycle against the scoreboard head
   task automatic serve(input int lat, input bit drop, input logic [DW-1:0] rd);
      exp_t e;
      int   t = 0;
      logic [NUM-1:0] one = 4'b0001;
      while (!m_wb_stb_o && t < 20) begin
         tick();
         t++;
      end
      check("stb_wait", {63'd0, m_wb_stb_o}, 64'd1);
      repeat (lat) tick();
      m_wb_ack_i = 1'b1;
      m_wb_dat_i = rd;
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 64'd1, 64'd0);
         e.m = 0; e.adr = '0; e.dat = '0; e.we = 0; e.sel = '0;
      end else e = sb.pop_front();
      check("grant", {62'd0, grant_o}, 64'(e.m));
      check("adr", {27'd0, m_wb_adr_o}, {27'd0, e.adr});
      check("wdat", m_wb_dat_o, e.dat);
      check("we", {63'd0, m_wb_we_o}, {63'd0, e.we});
      check("sel", {56'd0, m_wb_sel_o}, {56'd0, e.sel});
      check("ack_vec", {60'd0, s_wb_ack_o}, {60'd0, one << e.m});
      check("rdat", s_wb_dat_o, rd);
      tick();
      m_wb_ack_i = 1'b0;
      if (drop) begin
         s_wb_stb_i[e.m]  = 1'b0;
         s_wb_lock_i[e.m] = 1'b0;
      end
   endtask

   initial begin
      repeat (2) tick();
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_stb", {63'd0, m_wb_stb_o}, 64'd0);
      check("rst_ack", {60'd0, s_wb_ack_o}, 64'd0);
      check("rst_grant", {62'd0, grant_o}, 64'd0);
      reset_n = 1'b1;
      tick();

      // single master 1 read, 2-cycle slave
      set_req(1, 37'h0, 64'h0, 1'b0, 8'hff, 1'b0);
      push(1, 37'h0, 64'h0, 1'b0, 8'hff);
      #1;
      check("t1_stb_lat0", {63'd0, m_wb_stb_o}, 64'd0);
      tick();
      check("t1_stb_lat1", {63'd0, m_wb_stb_o}, 64'd1);
      serve(2, 1, 64'h0123456789abcdef);
      check("t1_busy_fall", {63'd0, busy_o}, 64'd0);

      // all four masters held, 1-cycle slave; last=1 so order resumes at 2
      for (int k = 0; k < NUM; k++) set_req(k, 37'(12'h100 + k), 64'(16'hA000 + k), 1'b1, 8'(k + 1), 1'b0);
      for (int n = 0; n < 6; n++) push((n + 2) % NUM, 37'(12'h100 + (n + 2) % NUM), 64'(16'hA000 + (n + 2) % NUM), 1'b1, 8'((n + 2) % NUM + 1));
      for (int n = 0; n < 6; n++) serve(0, 0, 64'(n));
      s_wb_stb_i = '0;
      tick();
      tick();

      // reset to get the 0,1,2,3,0,1 order from master 0
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < NUM; k++) set_req(k, 37'(12'h200 + k), 64'(16'hB000 + k), 1'b0, 8'hff, 1'b0);
      for (int n = 0; n < 6; n++) push(n % NUM, 37'(12'h200 + n % NUM), 64'(16'hB000 + n % NUM), 1'b0, 8'hff);
      for (int n = 0; n < 6; n++) serve(0, 0, 64'(n));
      s_wb_stb_i = '0;
      tick();
      tick();

      // locked read then write by master 2 while master 0 waits (last=1)
      set_req(2, 37'h1f0, 64'hdead_beef_0000_0002, 1'b0, 8'hff, 1'b1);
      set_req(0, 37'h010, 64'h1111, 1'b0, 8'hff, 1'b0);
      push(2, 37'h1f0, 64'hdead_beef_0000_0002, 1'b0, 8'hff);
      push(2, 37'h1f0, 64'hcafe_0000_0000_0002, 1'b1, 8'h0f);
      push(0, 37'h010, 64'h1111, 1'b0, 8'hff);
      tick();
      serve(1, 0, 64'h5);
      set_req(2, 37'h1f0, 64'hcafe_0000_0000_0002, 1'b1, 8'h0f, 1'b0);
      #1;
      check("t3_lock_grant", {62'd0, grant_o}, 64'd2);
      check("t3_lock_stb", {63'd0, m_wb_stb_o}, 64'd1);
      serve(1, 1, 64'h6);
      serve(0, 1, 64'h7);
      tick();

      // master 3 aborts without ack; masters 0 and 1 then compete, 0 wins (last=3)
      set_req(3, 37'h333, 64'h3, 1'b0, 8'hff, 1'b0);
      tick();
      check("t4_grant3", {62'd0, grant_o}, 64'd3);
      s_wb_stb_i[3] = 1'b0;
      set_req(0, 37'h040, 64'h40, 1'b1, 8'h01, 1'b0);
      set_req(1, 37'h041, 64'h41, 1'b1, 8'h02, 1'b0);
      push(0, 37'h040, 64'h40, 1'b1, 8'h01);
      push(1, 37'h041, 64'h41, 1'b1, 8'h02);
      tick();
      check("t4_abort_idle", {63'd0, busy_o}, 64'd0);
      tick();
      check("t4_next_grant", {62'd0, grant_o}, 64'd0);
      serve(0, 1, 64'h8);
      serve(0, 1, 64'h9);
      tick();

      // reset while busy with stb high
      set_req(2, 37'h222, 64'h22, 1'b0, 8'hff, 1'b0);
      tick();
      check("t5_busy", {63'd0, m_wb_stb_o}, 64'd1);
      reset_n = 1'b0;
      set_req(1, 37'h111, 64'h11, 1'b0, 8'hff, 1'b0);
      tick();
      check("t5_rst_stb", {63'd0, m_wb_stb_o}, 64'd0);
      check("t5_rst_grant", {62'd0, grant_o}, 64'd0);
      reset_n = 1'b1;
      push(1, 37'h111, 64'h11, 1'b0, 8'hff);
      push(2, 37'h222, 64'h22, 1'b0, 8'hff);
      tick();
      check("t5_first_grant", {62'd0, grant_o}, 64'd1);
      serve(0, 1, 64'hA);
      serve(0, 1, 64'hB);
      tick();

      // spurious slave ack in IDLE
      m_wb_ack_i = 1'b1;
      #1;
      check("t6_ack_idle", {60'd0, s_wb_ack_o}, 64'd0);
      tick();
      check("t6_busy", {63'd0, busy_o}, 64'd0);
      check("t6_grant", {62'd0, grant_o}, 64'd2);
      m_wb_ack_i = 1'b0;
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
